// File: rtl/symbol_feeder_if.sv
// Handshake and output bundle for symbol_feeder: producer side, stream side and fill level.
interface symbol_feeder_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [1:0]    in_sym;
  logic          in_valid;
  logic          in_ready;
  logic          hold;
  logic          flush;
  logic [1:0]    num;
  logic          num_valid;
  logic [LW-1:0] level;

  modport master (
    output in_sym, in_valid, hold, flush,
    input  in_ready, num, num_valid, level
  );

  modport slave (
    input  in_sym, in_valid, hold, flush,
    output in_ready, num, num_valid, level
  );
endinterface

// File: rtl/symbol_feeder.sv
// symbol_feeder: circular FIFO of nonzero 2-bit symbols that feeds a sequence
// detector one registered symbol per cycle; zero symbols are filtered out at the input.
module symbol_feeder #(
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            reset,
  symbol_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("symbol_feeder: DEPTH must be a power of two and at least 2");
  end

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    num_p0;
  logic          vld_p0;
  logic          accept;
  logic          write;
  logic          pop;

  // Ready drops while full, flushing or in reset; a zero symbol is accepted but never stored.
  assign bus.in_ready = (count < FULL) && !bus.flush && !reset;
  assign accept       = bus.in_valid && bus.in_ready;
  assign write        = accept && (bus.in_sym != 2'd0);
  // Pop looks only at the pre-edge count, so a push into an empty FIFO waits one cycle.
  assign pop          = (count != '0) && !bus.hold && !bus.flush;

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (write) begin
      mem[wr_ptr] <= bus.in_sym;
    end
  end

  // Stage p0: pointer/count bookkeeping and the registered output symbol; flush overrides push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      num_p0 <= 2'd0;
      vld_p0 <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      num_p0 <= 2'd0;
      vld_p0 <= 1'b0;
    end else begin
      if (write) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        num_p0 <= mem[rd_ptr];
        vld_p0 <= 1'b1;
      end else begin
        num_p0 <= 2'd0;
        vld_p0 <= 1'b0;
      end
      case ({write, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.num       = num_p0;
  assign bus.num_valid = vld_p0;
  assign bus.level     = count;
endmodule
